usb2_ep_in_arb: RTL
===================

# usb2_ep_in_arb

Round-robin arbiter that shares the write side of one double-buffered USB 2.0 endpoint among four byte-stream requesters. It sits in the `wr_clk` domain, in front of the endpoint buffer's write port. It grants one requester at a time and streams that requester's bytes into the current buffer half. It then performs the commit/commit-ack handshake with the endpoint, which runs in the `phy_clk` domain, before re-arbitrating.

## Interface
Parameters:
- `MAX_PKT`, default 512: maximum packet length in bytes, legal range 1..512; the packet closes automatically at this count.

Ports:
- `wr_clk`  in  1: the only clock; write-side clock of the endpoint buffer.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  4: per-requester request; held high while the requester owns or wants the endpoint.
- `req_data`  in  32: byte lanes; requester i drives bits [8i+7:8i].
- `req_valid`  in  4: byte on lane i is valid.
- `req_last`  in  4: byte on lane i is the final byte of the packet.
- `req_ready`  out  4: byte accepted on lane i.
- `grant`  out  4: one-hot current owner; all zero when idle.
- `buf_in_addr`  out  9: endpoint write address.
- `buf_in_data`  out  8: endpoint write data.
- `buf_in_wren`  out  1: endpoint write strobe.
- `buf_in_ready`  in  1: current buffer half is free (`phy_clk` domain).
- `buf_in_commit`  out  1: commit request, a level held until acknowledged.
- `buf_in_commit_len`  out  10: byte count of the committed packet.
- `buf_in_commit_ack`  in  1: commit acknowledge pulse, at least 4 `phy_clk` cycles wide.

## Operation
- `buf_in_ready` and `buf_in_commit_ack` each pass through a 2-flop synchronizer, producing `rdy_s` and `ack_s`.
- State machine:
  - IDLE: if any `req` is high and `rdy_s`=1, load `grant` with the selected requester, clear `cnt`, then go to STREAM.
  - STREAM: `req_ready[g]` = `grant[g]` and no other lane is ready. A byte transfers on `req_valid[g] & req_ready[g]`. On transfer, the next cycle registers `buf_in_data`=byte, `buf_in_addr`=`cnt[8:0]`, `buf_in_wren`=1, and `cnt` increments.
  - The packet closes in any of three cases, and the machine goes to COMMIT:
    - a transfer with `req_last` set;
    - a transfer that makes `cnt`==`MAX_PKT`;
    - `req[g]` dropping with no transfer in the same cycle (`cnt` may be 0, which gives a ZLP).
  - COMMIT: `buf_in_commit`=1 and `buf_in_commit_len`=`cnt`. Stay here until `ack_s`=1, then go to RELEASE.
  - RELEASE: `buf_in_commit`=0 and `grant`=0. Wait for `ack_s`=0, then go to IDLE.
- Round-robin selection: the search starts at (`last`+1) mod 4, where `last` is the most recently granted index. `last` resets to 3, so requester 0 wins first.
- `cnt` is 10 bits wide and never exceeds `MAX_PKT`. Address wrap is impossible because `MAX_PKT` ≤ 512.
- Requests arriving while a packet is in flight wait; no requester is starved beyond 3 packets.
- Asynchronous `reset` mid-packet aborts it. No commit is issued, the state returns to IDLE, and any partially written bytes are abandoned.

## Timing
- Reset values: `grant`=0, `req_ready`=0, `buf_in_wren`=0, `buf_in_addr`=0, `buf_in_data`=0, `buf_in_commit`=0, `buf_in_commit_len`=0, `last`=3, `cnt`=0, state IDLE.
- Grant latency: from `req` rising with `rdy_s` already high, `grant` goes high on the next edge. The first `req_ready` is high in the same cycle as `grant`.
- Throughput: 1 byte per cycle while `req_valid` is held. Write latency is 1 cycle from handshake to `buf_in_wren`.
- Commit: `buf_in_commit` rises the cycle after the final `buf_in_wren` pulse.
- `buf_in_commit_len` is stable from `buf_in_commit` rising until it falls.
- Commit falls 3 cycles after `buf_in_commit_ack` rises (2 synchronizer flops plus 1 state cycle).
- Minimum gap between packets: ack pulse width plus 4 cycles. IDLE then re-waits on `rdy_s`, which covers the buffer-swap latency.
- If `buf_in_ready` is low in IDLE (both buffer halves full), no grant is issued. `req` remains pending and loses no data.

## Configuration
- `USB2_EP_ARB_PRIO0_EN`, defined: requester 0 has strict priority. In IDLE it wins whenever `req[0]`=1; requesters 1..3 rotate round-robin among themselves. An in-flight packet is never pre-empted.
- Undefined: pure 4-way round-robin as above.

## Test plan
- Single requester 1 sends 5 bytes 0xA0..0xA4 with `req_last` on the fifth byte, `MAX_PKT`=512 → writes to addresses 0..4 with the same data; commit with len=5; after the ack, `grant`=0.
- All four requesters request continuously, each sending 2-byte packets → grant order 0,1,2,3,0; each commit len=2 (macro undefined).
- Same stimulus with `USB2_EP_ARB_PRIO0_EN` defined → grant order 0,0,0…; requester 1 is granted only after `req[0]` drops.
- Requester 2 streams 600 bytes with `MAX_PKT`=512 → first commit len=512 with last address 511; a second packet with len=88 follows after re-grant and `rdy_s`.
- `req[3]` pulses high then drops with no valid bytes → ZLP commit with len=0. With `buf_in_ready` held low, no grant is issued and `req_ready` stays 0.
- `reset` is asserted at byte 3 of a packet → all outputs return to their reset values on the same cycle, and no `buf_in_commit` is issued.

Source files
------------

// File: rtl/usb2_ep_in_arb.sv
// usb2_ep_in_arb: round-robin arbiter sharing one double-buffered USB 2.0 IN endpoint write port among 4 requesters.
// Define USB2_EP_ARB_PRIO0_EN to give requester 0 strict priority (1..3 still rotate among themselves).
module usb2_ep_in_arb #(
    parameter int MAX_PKT = 512
) (
    input  logic        wr_clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_valid,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [3:0]  grant,
    output logic [8:0]  buf_in_addr,
    output logic [7:0]  buf_in_data,
    output logic        buf_in_wren,
    input  logic        buf_in_ready,
    output logic        buf_in_commit,
    output logic [9:0]  buf_in_commit_len,
    input  logic        buf_in_commit_ack
);
    typedef enum logic [1:0] {IDLE, STREAM, COMMIT, RELEASE} state_t;
    state_t state, nxt;
    logic [1:0] rdy_q, ack_q, last, sel, idx;
    logic [9:0] cnt;
    logic rdy_s, ack_s, found, xfer, close;
    assign rdy_s = rdy_q[1];
    assign ack_s = ack_q[1];
    assign req_ready = (state == STREAM) ? grant : 4'b0;
    assign xfer = |(req_valid & req_ready);
    assign close = xfer ? (req_last[last] || cnt + 10'd1 == 10'(MAX_PKT)) : !req[last];
    assign buf_in_commit_len = buf_in_commit ? cnt : 10'd0;
    // Search starts one past the most recent owner so every requester gets a turn within 4 packets.
    always_comb begin
        sel = last;
        idx = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
`ifdef USB2_EP_ARB_PRIO0_EN
            if (!found && req[idx] && idx != 2'd0) begin
`else
            if (!found && req[idx]) begin
`endif
                sel = idx;
                found = 1'b1;
            end
        end
`ifdef USB2_EP_ARB_PRIO0_EN
        if (req[0]) begin
            sel = 2'd0;
            found = 1'b1;
        end
`endif
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (found && rdy_s) ? STREAM : IDLE;
            STREAM:  nxt = close ? COMMIT : STREAM;
            COMMIT:  nxt = ack_s ? RELEASE : COMMIT;
            RELEASE: nxt = ack_s ? RELEASE : IDLE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            rdy_q <= 2'b0;
            ack_q <= 2'b0;
        end else begin
            state <= nxt;
            rdy_q <= {rdy_q[0], buf_in_ready};
            ack_q <= {ack_q[0], buf_in_commit_ack};
        end
    end
    always_ff @(posedge wr_clk or posedge reset) begin
        if (reset) begin
            grant <= 4'b0;
            last <= 2'd3;
            cnt <= 10'd0;
            buf_in_wren <= 1'b0;
            buf_in_addr <= 9'd0;
            buf_in_data <= 8'd0;
            buf_in_commit <= 1'b0;
        end else begin
            buf_in_wren <= xfer;
            // Commit is withheld one cycle so it rises after the final write strobe.
            buf_in_commit <= (state == COMMIT) && !ack_s;
            if (xfer) begin
                buf_in_addr <= cnt[8:0];
                buf_in_data <= req_data[{last, 3'b000} +: 8];
                cnt <= cnt + 10'd1;
            end
            if (state == IDLE && nxt == STREAM) begin
                grant <= 4'b1 << sel;
                last <= sel;
                cnt <= 10'd0;
            end
            if (state == COMMIT && ack_s)
                grant <= 4'b0;
        end
    end
endmodule
